block_transfer_sequencer: RTL and testbench
===========================================

# block_transfer_sequencer

Multi-register transfer sequencer for block load/store instructions. On a start pulse it latches a 16-bit register list, a base address and the addressing-mode bits. It then issues one transfer per accepted handshake: a register address and its memory address, lowest-numbered register first at the lowest address. It sits between the control unit's instruction decode and the memory/register-file datapath, and is the consumer end of the register-list walk: it drives the datapath rather than merely reporting the next set bit.

## Interface
- ADDR_WIDTH, 32, width of base/memory/writeback addresses; word size fixed at 4 bytes
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request pulse; sampled only in IDLE
- reg_list  in  16  bit i set = transfer register i
- base_addr  in  ADDR_WIDTH  base register value
- pre  in  1  1 = pre-index (P), 0 = post-index
- up  in  1  1 = increment (U), 0 = decrement
- load  in  1  1 = load (memory→register), 0 = store
- ack  in  1  datapath accepted current transfer
- busy  out  1  high in every state except IDLE
- xfer_valid  out  1  current transfer presented
- reg_address  out  4  register of current transfer
- mem_addr  out  ADDR_WIDTH  word address of current transfer
- xfer_load  out  1  latched load bit
- last  out  1  current transfer is final one
- done  out  1  one-cycle completion pulse
- wb_addr  out  ADDR_WIDTH  base writeback value (BLOCK_XFER_WRITEBACK_EN only)
- wb_valid  out  1  wb_addr valid, coincident with done (BLOCK_XFER_WRITEBACK_EN only)

## Operation
- States: IDLE, XFER, DONE.
- IDLE: on start=1, latch reg_list into a pending mask; also latch base_addr, pre, up and load.
  - If reg_list≠0 → XFER; if reg_list=0 → DONE.
- n = popcount(reg_list), 5 bits, range 0..16.
- First address, modulo 2^ADDR_WIDTH (wrap allowed, no error):
  - up&pre: base+4
  - up&!pre: base
  - !up&pre: base−4n
  - !up&!pre: base−4n+4
- XFER: xfer_valid=1; reg_address = lowest set bit of the pending mask; last=1 when exactly one bit remains.
  - On ack: clear that bit and add 4 to mem_addr.
  - On ack with last=1 → DONE.
  - Without ack: all outputs hold.
- DONE: done=1 for exactly one cycle → IDLE.
- Writeback: wb_addr = up ? base+4n : base−4n. For an empty list, wb_addr = base.
- start while busy: ignored, no latch.
- ack outside XFER: ignored.
- Reset asserted mid-operation: abort immediately, return to IDLE, no done pulse.

## Timing
- Reset values: busy=0, xfer_valid=0, reg_address=0, mem_addr=0, xfer_load=0, last=0, done=0, wb_addr=0, wb_valid=0; state IDLE; pending mask 0.
- start sampled at edge k → xfer_valid=1 with the first transfer from edge k (i.e. visible in cycle k+1).
- One transfer per cycle with ack held high; an n-transfer list with continuous ack completes in n cycles, then done in cycle n+1.
- Empty list: start at edge k → done=1 in cycle k+1, busy=1 for that cycle only.
- All outputs registered; no combinational path from ack or start to outputs.
- A new start is accepted in the cycle after done (back-to-back allowed).

## Configuration
- BLOCK_XFER_WRITEBACK_EN defined:
  - wb_addr and wb_valid ports exist.
  - wb_addr is computed at start latch and held until the next accepted start or reset.
  - wb_valid pulses with done.
- Undefined: both ports and the writeback adder are absent; all other behaviour is identical.

## Structure
- Package block_xfer_pkg holds:
  - the state enum (IDLE, XFER, DONE)
  - WORD_BYTES=4
  - REG_COUNT=16
  - the popcount width constant.
- Sub-module lsb_encoder: combinational 16→4 lowest-set-bit priority encoder with a valid output. It is used for reg_address and next-state selection.
- Popcount and address arithmetic live in the top level.

## Test plan
- reg_list=0x8005, base=0x1000, up=1, pre=0, ack held 1 → transfers (R0,0x1000), (R2,0x1004), (R15,0x1008); last on R15; done next cycle; wb_addr=0x100C.
- reg_list=0x00F0, base=0x2000, up=0, pre=1, ack toggling 1,0 → R4..R7 at 0x1FF0,0x1FF4,0x1FF8,0x1FFC; outputs hold on ack=0 cycles; wb_addr=0x1FF0.
- reg_list=0x0000, start → no xfer_valid; done one cycle after start; wb_addr=base.
- reg_list=0xFFFF, base=0x0000_0000, up=0, pre=0 → first mem_addr=0xFFFF_FFC4 (wrap); 16 transfers; wb_addr=0xFFFF_FFC0.
- Mid-transfer start with a different list → ignored; original sequence completes unchanged.
- rst_n low during the third transfer → all outputs 0 asynchronously; no done; a new start after release runs normally.

Source files
------------

// File: rtl/block_xfer_pkg.sv
// Shared types and constants for the block transfer sequencer.
package block_xfer_pkg;

    localparam int WORD_BYTES = 4;
    localparam int REG_COUNT  = 16;
    // Popcount of a 16-bit list spans 0..16, so it needs 5 bits.
    localparam int CNT_W      = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/lsb_encoder.sv
// Lowest-set-bit priority encoder: 16-bit mask to 4-bit index plus valid.
module lsb_encoder
    import block_xfer_pkg::*;
(
    input  logic [REG_COUNT-1:0] mask,
    output logic [3:0]           index,
    output logic                 valid
);

    // Scan from the top down so the lowest set bit wins the last assignment.
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        index = 4'd0;
        valid = 1'b0;
        for (int i = REG_COUNT - 1; i >= 0; i--) begin
            if (mask[i]) begin
                index = 4'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/block_transfer_sequencer.sv
// Block load/store transfer sequencer: walks a latched register list and
// presents one (register, word address) transfer per accepted handshake.
// Optional base writeback output is enabled by BLOCK_XFER_WRITEBACK_EN.
module block_transfer_sequencer
    import block_xfer_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [REG_COUNT-1:0]  reg_list,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic                  pre,
    input  logic                  up,
    input  logic                  load,
    input  logic                  ack,
    output logic                  busy,
    output logic                  xfer_valid,
    output logic [3:0]            reg_address,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  xfer_load,
    output logic                  last,
    output logic                  done
`ifdef BLOCK_XFER_WRITEBACK_EN
    ,
    output logic [ADDR_WIDTH-1:0] wb_addr,
    output logic                  wb_valid
`endif
);

    localparam logic [ADDR_WIDTH-1:0] WORD = ADDR_WIDTH'(WORD_BYTES);

    state_t                state;
    logic [REG_COUNT-1:0]  pending;
    logic [REG_COUNT-1:0]  mask_next;
    logic [3:0]            enc_index;
    logic                  enc_valid;
    logic                  one_left;
    logic [CNT_W-1:0]      n_regs;
    logic [ADDR_WIDTH-1:0] span;
    logic [ADDR_WIDTH-1:0] first_addr;

    function automatic logic [CNT_W-1:0] popcount(input logic [REG_COUNT-1:0] m);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < REG_COUNT; i++) c = c + CNT_W'(m[i]);
        return c;
    endfunction

    // Mask the next register is picked from: the incoming list when idle,
    // the pending mask minus the current register on an accepted transfer.
    always_comb begin
        mask_next = pending;
        if (state == IDLE)
            mask_next = reg_list;
        else if (state == XFER && ack)
            mask_next = pending & ~(REG_COUNT'(1) << reg_address);
    end

    lsb_encoder u_lsb_encoder (
        .mask  (mask_next),
        .index (enc_index),
        .valid (enc_valid)
    );

    // Exactly one bit left in the next mask means the next transfer is the final one.
    assign one_left = enc_valid && ((mask_next & (mask_next - REG_COUNT'(1))) == '0);

    // Start address of the block: the walk always ascends from the lowest word.
    always_comb begin
        n_regs = popcount(reg_list);
        span   = ADDR_WIDTH'(n_regs) << 2;
        case ({up, pre})
            2'b11:   first_addr = base_addr + WORD;
            2'b10:   first_addr = base_addr;
            2'b01:   first_addr = base_addr - span;
            default: first_addr = base_addr - span + WORD;
        endcase
    end

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pending     <= '0;
            busy        <= 1'b0;
            xfer_valid  <= 1'b0;
            reg_address <= 4'd0;
            mem_addr    <= '0;
            xfer_load   <= 1'b0;
            last        <= 1'b0;
            done        <= 1'b0;
`ifdef BLOCK_XFER_WRITEBACK_EN
            wb_addr     <= '0;
            wb_valid    <= 1'b0;
`endif
        end else begin
            // NOTE: state and outputs use non-blocking assignments so every read in this block sees pre-edge values.
            case (state)
                IDLE: begin
                    done <= 1'b0;
`ifdef BLOCK_XFER_WRITEBACK_EN
                    wb_valid <= 1'b0;
`endif
                    if (start) begin
                        pending   <= reg_list;
                        xfer_load <= load;
                        mem_addr  <= first_addr;
                        busy      <= 1'b1;
`ifdef BLOCK_XFER_WRITEBACK_EN
                        wb_addr   <= up ? base_addr + span : base_addr - span;
`endif
                        if (enc_valid) begin
                            state       <= XFER;
                            xfer_valid  <= 1'b1;
                            reg_address <= enc_index;
                            last        <= one_left;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
`ifdef BLOCK_XFER_WRITEBACK_EN
                            wb_valid <= 1'b1;
`endif
                        end
                    end
                end
                XFER: begin
                    if (ack) begin
                        pending  <= mask_next;
                        mem_addr <= mem_addr + WORD;
                        if (last) begin
                            state      <= DONE;
                            xfer_valid <= 1'b0;
                            last       <= 1'b0;
                            done       <= 1'b1;
`ifdef BLOCK_XFER_WRITEBACK_EN
                            wb_valid   <= 1'b1;
`endif
                        end else begin
                            reg_address <= enc_index;
                            last        <= one_left;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
`ifdef BLOCK_XFER_WRITEBACK_EN
                    wb_valid <= 1'b0;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_block_transfer_sequencer.sv
// Self-checking bench for block_transfer_sequencer using a transfer scoreboard.
module tb_block_transfer_sequencer;

    typedef struct {
        logic [3:0]  rnum;
        logic [31:0] addr;
        logic        lst;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] reg_list;
    logic [31:0] base_addr;
    logic        pre;
    logic        up;
    logic        load;
    logic        ack;
    logic        busy;
    logic        xfer_valid;
    logic [3:0]  reg_address;
    logic [31:0] mem_addr;
    logic        xfer_load;
    logic        last;
    logic        done;
`ifdef BLOCK_XFER_WRITEBACK_EN
    logic [31:0] wb_addr;
    logic        wb_valid;
`endif

    int checks   = 0;
    int failures = 0;

    block_transfer_sequencer #(.ADDR_WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .reg_list    (reg_list),
        .base_addr   (base_addr),
        .pre         (pre),
        .up          (up),
        .load        (load),
        .ack         (ack),
        .busy        (busy),
        .xfer_valid  (xfer_valid),
        .reg_address (reg_address),
        .mem_addr    (mem_addr),
        .xfer_load   (xfer_load),
        .last        (last),
        .done        (done)
`ifdef BLOCK_XFER_WRITEBACK_EN
        ,
        .wb_addr     (wb_addr),
        .wb_valid    (wb_valid)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".busy"},        busy,        0);
        check({tag, ".xfer_valid"},  xfer_valid,  0);
        check({tag, ".reg_address"}, reg_address, 0);
        check({tag, ".mem_addr"},    mem_addr,    0);
        check({tag, ".xfer_load"},   xfer_load,   0);
        check({tag, ".last"},        last,        0);
        check({tag, ".done"},        done,        0);
`ifdef BLOCK_XFER_WRITEBACK_EN
        check({tag, ".wb_addr"},     wb_addr,     0);
        check({tag, ".wb_valid"},    wb_valid,    0);
`endif
    endtask

    // ack_mode 0: ack held high; 1: ack toggles 1,0,1,0...
    // inject: drive a conflicting start while the sequence is in flight.
    task automatic run_seq(input string name, input logic [15:0] list, input logic [31:0] base,
                           input logic p, input logic u, input logic ld,
                           input int ack_mode, input bit inject);
        exp_t        q[$];
        exp_t        e;
        int          n;
        int          cyc;
        bit          exp_done;
        logic [31:0] a;
        logic [31:0] exp_wb;

        n = 0;
        for (int i = 0; i < 16; i++) if (list[i]) n++;
        // Block spans [lowest, lowest + 4n); derive lowest from base and mode.
        if (u) a = p ? base + 32'd4 : base;
        else   a = p ? base - 32'(4 * n) : base - 32'(4 * n) + 32'd4;
        exp_wb = u ? base + 32'(4 * n) : base - 32'(4 * n);
        for (int i = 0, k = 0; i < 16; i++) begin
            if (list[i]) begin
                k++;
                e.rnum = 4'(i);
                e.addr = a;
                e.lst  = (k == n);
                q.push_back(e);
                a = a + 32'd4;
            end
        end

        @(posedge clk); #1;
        start = 1'b1; reg_list = list; base_addr = base; pre = p; up = u; load = ld; ack = 1'b0;
        @(posedge clk); #1;
        start = 1'b0; reg_list = 16'h0F0F; base_addr = 32'hDEAD_0000; pre = ~p; up = ~u; load = ~ld;

        exp_done = (q.size() == 0);
        cyc = 1;
        forever begin
            ack = (ack_mode == 0) ? 1'b1 : logic'(cyc % 2);
            if (inject && cyc == 2) begin
                start = 1'b1; reg_list = 16'h0F00; base_addr = 32'h5000;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            check({name, ".busy"},       busy,       1);
            check({name, ".xfer_valid"}, xfer_valid, !exp_done);
            check({name, ".done"},       done,       exp_done);
            if (xfer_valid && q.size() > 0) begin
                check({name, ".reg_address"}, reg_address, q[0].rnum);
                check({name, ".mem_addr"},    mem_addr,    q[0].addr);
                check({name, ".last"},        last,        q[0].lst);
                check({name, ".xfer_load"},   xfer_load,   ld);
            end
`ifdef BLOCK_XFER_WRITEBACK_EN
            check({name, ".wb_valid"}, wb_valid, exp_done);
            if (exp_done) check({name, ".wb_addr"}, wb_addr, exp_wb);
`endif
            if (exp_done) break;
            if (ack && xfer_valid && q.size() > 0) begin
                void'(q.pop_front());
                if (q.size() == 0) exp_done = 1'b1;
            end
            if (cyc > 60) begin
                check({name, ".timeout"}, cyc, 0);
                break;
            end
            @(posedge clk); #1;
            cyc++;
        end
        @(posedge clk); #1;
        start = 1'b0; ack = 1'b0;
        @(negedge clk);
        check({name, ".idle_busy"}, busy, 0);
        check({name, ".idle_done"}, done, 0);
        check({name, ".idle_xv"},   xfer_valid, 0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; reg_list = '0; base_addr = '0;
        pre = 1'b0; up = 1'b0; load = 1'b0; ack = 1'b0;
        #12;
        check_all_zero("reset");
        @(negedge clk); rst_n = 1'b1;

        run_seq("up_post",   16'h8005, 32'h0000_1000, 1'b0, 1'b1, 1'b1, 0, 1'b0);
        run_seq("dn_pre",    16'h00F0, 32'h0000_2000, 1'b1, 1'b0, 1'b0, 1, 1'b0);
        run_seq("empty",     16'h0000, 32'h0000_7000, 1'b0, 1'b1, 1'b0, 0, 1'b0);
        run_seq("wrap_all",  16'hFFFF, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 0, 1'b0);
        run_seq("inject",    16'h0222, 32'h0000_4000, 1'b1, 1'b1, 1'b0, 0, 1'b1);

        // Reset during the third transfer of an 8-register block.
        @(posedge clk); #1;
        start = 1'b1; reg_list = 16'h00FF; base_addr = 32'h3000; pre = 1'b0; up = 1'b1; load = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; ack = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_mid.reg_address", reg_address, 2);
        check("rst_mid.mem_addr",    mem_addr,    32'h3008);
        #2 rst_n = 1'b0;
        #1 check_all_zero("rst_async");
        ack = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("rst_hold.done", done, 0);
            check("rst_hold.busy", busy, 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_after.done", done, 0);

        run_seq("post_rst",  16'h0009, 32'h0000_0100, 1'b1, 1'b0, 1'b1, 1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
